video_tile_buffer: RTL

- Double-buffered 10x10 tile framebuffer sitting directly upstream of the VGA timing/output stage.
- CPU-side writes land in a back buffer through a valid/ready port. A commit request swaps the buffers at the next frame start, so a frame never tears.
- Pixel side walks the 640x480 visible area in 64x48-pixel tiles. It returns the RGB332 colour of the current tile, 2-cycle latency, and also exports a 100-bit tile-occupancy vector.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/tile_walker.sv | 89 ++++++++
 rtl/video_tile_buffer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA geometry, tile constants and RGB332 helpers
//
// Purpose: constants and types shared by the tile framebuffer and its
//          pixel walker. No ports (package).
package vga_pkg;

  localparam int H_VISIBLE  = 640;
  localparam int V_VISIBLE  = 480;

  localparam int TILES_X    = 10;
  localparam int TILES_Y    = 10;
  localparam int TILE_W     = 64;
  localparam int TILE_H     = 48;
  localparam int NUM_TILES  = TILES_X * TILES_Y;
  localparam int TILE_IDX_W = 7;

  // RGB332: {r[2:0], g[2:0], b[1:0]}
  typedef logic [7:0] rgb332_t;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } commit_state_t;

  function automatic logic [2:0] rgb_r(input rgb332_t c);
    return c[7:5];
  endfunction

  function automatic logic [2:0] rgb_g(input rgb332_t c);
    return c[4:2];
  endfunction

  function automatic logic [1:0] rgb_b(input rgb332_t c);
    return c[1:0];
  endfunction

endpackage

// File: rtl/tile_walker.sv
// rtl/tile_walker.sv - pixel walk counters and tile index (pipeline stage 1)
//
// Purpose: tracks the position of the visible pixel stream in tile units
//          and registers the linear tile index of the current pixel.
// Ports:
//   clk_25m, rst_n  pixel clock, async active-low reset
//   frame_start     clears all counters (wins over pix_valid)
//   pix_valid       advance counters, current cycle is a visible pixel
//   idx             registered tile index row*TILES_X+col
//   idx_valid       pix_valid delayed one cycle, qualifies idx
module tile_walker
  import vga_pkg::*;
#(
  parameter int TILES_X = vga_pkg::TILES_X,
  parameter int TILES_Y = vga_pkg::TILES_Y,
  parameter int TILE_W  = vga_pkg::TILE_W,
  parameter int TILE_H  = vga_pkg::TILE_H
) (
  input  logic                  clk_25m,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  output logic [TILE_IDX_W-1:0] idx,
  output logic                  idx_valid
);

  localparam int XW = $clog2(TILE_W);
  localparam int CW = $clog2(TILES_X);
  localparam int YW = $clog2(TILE_H);
  localparam int RW = $clog2(TILES_Y);

  logic [XW-1:0] sub_x;
  logic [CW-1:0] tile_col;
  logic [YW-1:0] sub_y;
  logic [RW-1:0] tile_row;

  logic                  end_of_tile_x;
  logic                  end_of_line;
  logic                  end_of_tile_y;
  logic [TILE_IDX_W-1:0] row_ext;
  logic [TILE_IDX_W-1:0] lin_idx;

  assign end_of_tile_x = (sub_x == XW'(TILE_W - 1));
  assign end_of_line   = end_of_tile_x && (tile_col == CW'(TILES_X - 1));
  assign end_of_tile_y = (sub_y == YW'(TILE_H - 1));

  // row*10 as row*8 + row*2 keeps a multiplier out of the pixel path
  assign row_ext = TILE_IDX_W'(tile_row);
  assign lin_idx = (row_ext << 3) + (row_ext << 1) + TILE_IDX_W'(tile_col);

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      sub_x     <= '0;
      tile_col  <= '0;
      sub_y     <= '0;
      tile_row  <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
    end else begin
      idx       <= lin_idx;
      idx_valid <= pix_valid;
      if (frame_start) begin
        sub_x    <= '0;
        tile_col <= '0;
        sub_y    <= '0;
        tile_row <= '0;
      end else if (pix_valid) begin
        if (!end_of_tile_x) begin
          sub_x <= sub_x + 1'b1;
        end else begin
          sub_x <= '0;
          if (!end_of_line) begin
            tile_col <= tile_col + 1'b1;
          end else begin
            tile_col <= '0;
            if (!end_of_tile_y) begin
              sub_y <= sub_y + 1'b1;
            end else begin
              sub_y <= '0;
              // lines past the visible area keep addressing the last row
              if (tile_row != RW'(TILES_Y - 1)) tile_row <= tile_row + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/video_tile_buffer.sv
// rtl/video_tile_buffer.sv - double-buffered 10x10 tile framebuffer for VGA output
//
// Purpose: CPU writes go to the back buffer; a commit swaps buffers at the
//          next frame_start so a displayed frame never tears. The pixel side
//          returns the front-buffer colour of the current tile, 2 cycles late.
// Ports:
//   clk_25m, rst_n                 pixel clock, async active-low reset
//   wr_valid/wr_ready              CPU write handshake
//   wr_addr, wr_colour             tile index (0..99) and RGB332 colour
//   wr_err                         1-cycle pulse for a dropped out-of-range write
//   commit_req, commit_pending     swap request (level) and pending flag
//   frame_start, pix_valid         timing-stage frame pulse and visible pixel
//   pix_rgb, pix_out_valid         tile colour and its qualifier
//   tile_on                        per-tile non-zero flag of the front buffer
module video_tile_buffer
  import vga_pkg::*;
#(
  parameter int      TILES_X      = vga_pkg::TILES_X,
  parameter int      TILES_Y      = vga_pkg::TILES_Y,
  parameter int      TILE_W       = vga_pkg::TILE_W,
  parameter int      TILE_H       = vga_pkg::TILE_H,
  parameter rgb332_t RESET_COLOUR = 8'h00
) (
  input  logic                       clk_25m,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [TILE_IDX_W-1:0]      wr_addr,
  input  rgb332_t                    wr_colour,
  output logic                       wr_err,
  input  logic                       commit_req,
  output logic                       commit_pending,
  input  logic                       frame_start,
  input  logic                       pix_valid,
  output rgb332_t                    pix_rgb,
  output logic                       pix_out_valid,
  output logic [TILES_X*TILES_Y-1:0] tile_on
);

  localparam int N_TILES = TILES_X * TILES_Y;

  rgb332_t               mem [2][N_TILES];
  logic                  front_sel;
  commit_state_t         state_q;
  commit_state_t         state_d;
  logic                  do_swap;
  logic                  wr_accept;
  logic                  wr_in_range;
  logic [TILE_IDX_W-1:0] rd_idx;
  logic                  rd_valid;

  assign wr_accept      = wr_valid && wr_ready;
  assign wr_in_range    = (wr_addr < TILE_IDX_W'(N_TILES));
  assign commit_pending = (state_q == ST_PENDING);

  always_comb begin
    state_d = state_q;
    do_swap = 1'b0;
    case (state_q)
      ST_IDLE:    if (commit_req) state_d = ST_PENDING;
      ST_PENDING: if (frame_start) begin
        state_d = ST_IDLE;
        do_swap = 1'b1;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // wr_ready is registered from the next state so it tracks !commit_pending
  // exactly, while still reading 0 during reset.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wr_ready  <= 1'b0;
      wr_err    <= 1'b0;
      front_sel <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ready <= (state_d == ST_IDLE);
      wr_err   <= wr_accept && !wr_in_range;
      if (do_swap) front_sel <= ~front_sel;
    end
  end

  // On a swap the old back becomes front and is copied over the old front,
  // so the new back starts as the displayed image. Writes are blocked while
  // pending, so a write and a swap never coincide.
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_TILES; i++) mem[b][i] <= RESET_COLOUR;
      end
    end else if (do_swap) begin
      for (int i = 0; i < N_TILES; i++) mem[front_sel][i] <= mem[~front_sel][i];
    end else if (wr_accept && wr_in_range) begin
      mem[~front_sel][wr_addr] <= wr_colour;
    end
  end

  tile_walker #(
    .TILES_X (TILES_X),
    .TILES_Y (TILES_Y),
    .TILE_W  (TILE_W),
    .TILE_H  (TILE_H)
  ) u_walker (
    .clk_25m     (clk_25m),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .idx         (rd_idx),
    .idx_valid   (rd_valid)
  );

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      pix_rgb       <= 8'h00;
      pix_out_valid <= 1'b0;
      tile_on       <= {N_TILES{RESET_COLOUR != 8'h00}};
    end else begin
      pix_out_valid <= rd_valid;
      pix_rgb       <= rd_valid ? mem[front_sel][rd_idx] : 8'h00;
      for (int i = 0; i < N_TILES; i++) tile_on[i] <= (mem[front_sel][i] != 8'h00);
    end
  end

endmodule
